// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode encodings, default widths and the
// reservation-station entry record.
package tomasulo_pkg;

    localparam int RS_TAG_W  = 3;
    localparam int RS_DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    typedef struct packed {
        logic                 busy;
        logic [RS_DATA_W-1:0] inst;
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_DATA_W-1:0] Vj;
        logic [RS_TAG_W-1:0]  Qj;
        logic                 rj;
        logic [RS_DATA_W-1:0] Vk;
        logic [RS_TAG_W-1:0]  Qk;
        logic                 rk;
    } rs_entry_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and functional-unit signals of the reservation station.
interface reservation_station_if
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int TAG_W  = RS_TAG_W,
    parameter int DATA_W = RS_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_inst;
    logic [TAG_W-1:0]  issue_tag;
    logic              src1_rdy;
    logic [DATA_W-1:0] src1_val;
    logic [TAG_W-1:0]  src1_tag;
    logic              src2_rdy;
    logic [DATA_W-1:0] src2_val;
    logic [TAG_W-1:0]  src2_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              fu_avail;
    logic [DATA_W-1:0] fu_inst;
    logic              fu_inst_valid;
    logic [TAG_W-1:0]  fu_tag;
    logic [DATA_W-1:0] fu_r1;
    logic [DATA_W-1:0] fu_r2;
    logic              issue_err;
    logic [CNT_W-1:0]  count;

    modport master (
        output issue_valid, issue_inst, issue_tag,
               src1_rdy, src1_val, src1_tag, src2_rdy, src2_val, src2_tag,
               cdb_valid, cdb_tag, cdb_data, fu_avail,
        input  issue_ready, fu_inst, fu_inst_valid, fu_tag, fu_r1, fu_r2,
               issue_err, count
    );

    modport slave (
        input  issue_valid, issue_inst, issue_tag,
               src1_rdy, src1_val, src1_tag, src2_rdy, src2_val, src2_tag,
               cdb_valid, cdb_tag, cdb_data, fu_avail,
        output issue_ready, fu_inst, fu_inst_valid, fu_tag, fu_r1, fu_r2,
               issue_err, count
    );

endinterface

// File: rtl/rs_priority_pick.sv
// Lowest-index one-hot picker over a request vector.
module rs_priority_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: issue with CDB forwarding, operand snooping,
// and single-strobe dispatch of the lowest-index ready entry.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int TAG_W  = RS_TAG_W,
    parameter int DATA_W = RS_DATA_W
) (
    input logic                  clock,
    input logic                  reset,
    reservation_station_if.slave rs
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t         ent_q [DEPTH];
    rs_entry_t         ent_d [DEPTH];
    logic [DEPTH-1:0]  free_vec, free_oh, rdy_vec, rdy_oh;
    logic              do_issue, do_disp, legal, fwd1, fwd2;
    logic [DATA_W-1:0] sel_inst, sel_vj, sel_vk;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] fu_inst_q, fu_r1_q, fu_r2_q;
    logic [TAG_W-1:0]  fu_tag_q;
    logic              fu_vld_q, err_q;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        free_vec = '0;
        rdy_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !ent_q[i].busy;
            rdy_vec[i]  = ent_q[i].busy && ent_q[i].rj && ent_q[i].rk;
        end
    end

    rs_priority_pick #(.N(DEPTH)) u_free_pick (.req_i(free_vec), .gnt_o(free_oh));
    rs_priority_pick #(.N(DEPTH)) u_rdy_pick  (.req_i(rdy_vec),  .gnt_o(rdy_oh));

    // issue_ready looks only at registered busy bits, so a dispatch in the
    // same cycle cannot open a slot for the issuer.
    assign rs.issue_ready = |free_vec;
    assign legal          = op_legal(rs.issue_inst[3:0]);
    assign do_issue       = rs.issue_valid && rs.issue_ready && legal;
    assign do_disp        = rs.fu_avail && !fu_vld_q && (|rdy_vec);
    assign fwd1           = rs.cdb_valid && (rs.cdb_tag == rs.src1_tag);
    assign fwd2           = rs.cdb_valid && (rs.cdb_tag == rs.src2_tag);
    assign count_d        = count_q + CNT_W'(do_issue) - CNT_W'(do_disp);

    always_comb begin
        sel_inst = '0;
        sel_tag  = '0;
        sel_vj   = '0;
        sel_vk   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy_oh[i]) begin
                sel_inst = ent_q[i].inst;
                sel_tag  = ent_q[i].tag;
                sel_vj   = ent_q[i].Vj;
                sel_vk   = ent_q[i].Vk;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && rs.cdb_valid) begin
                if (!ent_q[i].rj && ent_q[i].Qj == rs.cdb_tag) begin
                    ent_d[i].Vj = rs.cdb_data;
                    ent_d[i].rj = 1'b1;
                end
                if (!ent_q[i].rk && ent_q[i].Qk == rs.cdb_tag) begin
                    ent_d[i].Vk = rs.cdb_data;
                    ent_d[i].rk = 1'b1;
                end
            end
            if (do_disp && rdy_oh[i]) ent_d[i].busy = 1'b0;
            // The issue slot is free, so it never collides with the dispatch slot.
            if (do_issue && free_oh[i]) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].inst = rs.issue_inst;
                ent_d[i].tag  = rs.issue_tag;
                ent_d[i].Qj   = rs.src1_tag;
                ent_d[i].rj   = rs.src1_rdy || fwd1;
                ent_d[i].Vj   = rs.src1_rdy ? rs.src1_val : rs.cdb_data;
                ent_d[i].Qk   = rs.src2_tag;
                ent_d[i].rk   = rs.src2_rdy || fwd2;
                ent_d[i].Vk   = rs.src2_rdy ? rs.src2_val : rs.cdb_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            fu_inst_q <= '0;
            fu_tag_q  <= '0;
            fu_r1_q   <= '0;
            fu_r2_q   <= '0;
            fu_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            if (do_disp) begin
                fu_inst_q <= sel_inst;
                fu_tag_q  <= sel_tag;
                fu_r2_q   <= sel_vj;
                fu_r1_q   <= sel_vk;
            end
            fu_vld_q <= do_disp;
            err_q    <= rs.issue_valid && rs.issue_ready && !legal;
            count_q  <= count_d;
        end
    end

    assign rs.fu_inst       = fu_inst_q;
    assign rs.fu_tag        = fu_tag_q;
    assign rs.fu_r1         = fu_r1_q;
    assign rs.fu_r2         = fu_r2_q;
    assign rs.fu_inst_valid = fu_vld_q;
    assign rs.issue_err     = err_q;
    assign rs.count         = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, CDB capture/forwarding,
// full-station back-pressure, illegal opcodes and reset during dispatch.
module tb_reservation_station;
    import tomasulo_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    reservation_station_if #(.DEPTH(3)) bus ();

    reservation_station #(.DEPTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .rs    (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_issue(input logic [15:0] inst, input logic [2:0] tag,
                             input logic r1, input logic [15:0] v1, input logic [2:0] t1,
                             input logic r2, input logic [15:0] v2, input logic [2:0] t2);
        bus.issue_valid = 1'b1;
        bus.issue_inst  = inst;
        bus.issue_tag   = tag;
        bus.src1_rdy    = r1;
        bus.src1_val    = v1;
        bus.src1_tag    = t1;
        bus.src2_rdy    = r2;
        bus.src2_val    = v2;
        bus.src2_tag    = t2;
    endtask

    task automatic chk_disp(input string tag, input logic [15:0] inst, input logic [2:0] ftag,
                            input logic [15:0] r2, input logic [15:0] r1);
        chk({tag, "_valid"}, bus.fu_inst_valid, 1);
        chk({tag, "_inst"},  bus.fu_inst, inst);
        chk({tag, "_tag"},   bus.fu_tag, ftag);
        chk({tag, "_r2"},    bus.fu_r2, r2);
        chk({tag, "_r1"},    bus.fu_r1, r1);
    endtask

    initial begin
        bus.issue_valid = 0; bus.issue_inst = 0; bus.issue_tag = 0;
        bus.src1_rdy = 0; bus.src1_val = 0; bus.src1_tag = 0;
        bus.src2_rdy = 0; bus.src2_val = 0; bus.src2_tag = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.fu_avail = 0;
        tick(); tick();
        reset = 0;
        chk("rst_valid", bus.fu_inst_valid, 0);
        chk("rst_inst",  bus.fu_inst, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.issue_ready, 1);
        chk("rst_err",   bus.issue_err, 0);

        // 1: both operands ready, dispatch on the edge after issue
        bus.fu_avail = 1;
        set_issue(16'h0000, 3'd1, 1, 16'd5, 3'd0, 1, 16'd3, 3'd0);
        tick();
        bus.issue_valid = 0;
        chk("t1_count1", bus.count, 1);
        chk("t1_novalid", bus.fu_inst_valid, 0);
        tick();
        chk_disp("t1_disp", 16'h0000, 3'd1, 16'd5, 16'd3);
        chk("t1_count0", bus.count, 0);
        tick();
        chk("t1_strobe1cyc", bus.fu_inst_valid, 0);
        chk("t1_hold_r2", bus.fu_r2, 16'd5);

        // 2: src1 waits on tag 2, captured from the CDB later
        set_issue(16'h0001, 3'd3, 0, 16'hdead, 3'd2, 1, 16'd4, 3'd0);
        tick();
        bus.issue_valid = 0;
        chk("t2_count", bus.count, 1);
        tick();
        chk("t2_wait", bus.fu_inst_valid, 0);
        bus.cdb_valid = 1; bus.cdb_tag = 3'd2; bus.cdb_data = 16'd10;
        tick();
        bus.cdb_valid = 0;
        chk("t2_nobypass", bus.fu_inst_valid, 0);
        tick();
        chk_disp("t2_disp", 16'h0001, 3'd3, 16'd10, 16'd4);
        tick();

        // 3: issue-time forwarding on src2; ready src1 ignores a matching CDB
        set_issue(16'h0004, 3'd4, 1, 16'd7, 3'd5, 0, 16'hbeef, 3'd5);
        bus.cdb_valid = 1; bus.cdb_tag = 3'd5; bus.cdb_data = 16'h0020;
        tick();
        bus.issue_valid = 0; bus.cdb_valid = 0;
        chk("t3_count", bus.count, 1);
        tick();
        chk_disp("t3_disp", 16'h0004, 3'd4, 16'd7, 16'h0020);
        tick();

        // 4: fill the station, back-pressure, then in-order drain
        bus.fu_avail = 0;
        set_issue(16'h0005, 3'd1, 1, 16'h0011, 3'd0, 1, 16'h0000, 3'd0);
        tick();
        set_issue(16'h0000, 3'd2, 1, 16'h0021, 3'd0, 1, 16'h0022, 3'd0);
        tick();
        set_issue(16'h0001, 3'd3, 1, 16'h0031, 3'd0, 1, 16'h0032, 3'd0);
        tick();
        chk("t4_full_count", bus.count, 3);
        chk("t4_full_ready", bus.issue_ready, 0);
        set_issue(16'h0000, 3'd6, 1, 16'h0041, 3'd0, 1, 16'h0042, 3'd0);
        tick();
        chk("t4_ignored", bus.count, 3);
        chk("t4_nodisp", bus.fu_inst_valid, 0);
        bus.fu_avail = 1;
        chk("t4_ready_still0", bus.issue_ready, 0);
        tick();
        bus.issue_valid = 0;
        chk_disp("t4_d0", 16'h0005, 3'd1, 16'h0011, 16'h0000);
        chk("t4_count2", bus.count, 2);
        tick();
        chk("t4_gap", bus.fu_inst_valid, 0);
        tick();
        chk_disp("t4_d1", 16'h0000, 3'd2, 16'h0021, 16'h0022);
        tick();
        chk("t4_gap2", bus.fu_inst_valid, 0);
        tick();
        chk_disp("t4_d2", 16'h0001, 3'd3, 16'h0031, 16'h0032);
        chk("t4_count0", bus.count, 0);
        tick();

        // 5: illegal opcode
        set_issue(16'h0002, 3'd7, 1, 16'd1, 3'd0, 1, 16'd1, 3'd0);
        tick();
        bus.issue_valid = 0;
        chk("t5_err", bus.issue_err, 1);
        chk("t5_count", bus.count, 0);
        tick();
        chk("t5_err_pulse", bus.issue_err, 0);
        chk("t5_nodisp", bus.fu_inst_valid, 0);
        tick();
        chk("t5_nodisp2", bus.fu_inst_valid, 0);

        // 6: reset while the dispatch strobe is high
        bus.fu_avail = 0;
        set_issue(16'h0000, 3'd1, 1, 16'd1, 3'd0, 1, 16'd2, 3'd0);
        tick();
        set_issue(16'h0000, 3'd2, 1, 16'd3, 3'd0, 1, 16'd4, 3'd0);
        tick();
        bus.issue_valid = 0;
        bus.fu_avail = 1;
        tick();
        chk_disp("t6_disp", 16'h0000, 3'd1, 16'd1, 16'd2);
        reset = 1;
        tick();
        reset = 0;
        chk("t6_valid", bus.fu_inst_valid, 0);
        chk("t6_tag", bus.fu_tag, 0);
        chk("t6_r1", bus.fu_r1, 0);
        chk("t6_r2", bus.fu_r2, 0);
        chk("t6_count", bus.count, 0);
        chk("t6_ready", bus.issue_ready, 1);
        tick();
        chk("t6_flushed", bus.fu_inst_valid, 0);
        tick();
        chk("t6_flushed2", bus.fu_inst_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
